// File: rtl/jtbubl_romarb.sv
// Arbiter for one 32-bit graphics ROM slot shared by a tile fetcher (A) and an object fetcher (B).
// Each requester keeps a one-word cache, so repeated reads of the same address never reach the ROM.
module jtbubl_romarb #(
  parameter int AW    = 18,
  parameter int DW    = 32,
  parameter int OKDLY = 1,
  parameter int PRIO  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_data,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(OKDLY);
  localparam logic       RR       = (PRIO == 0);

  state_t        r_state,    w_state_nxt;
  logic [1:0]    r_cnt,      w_cnt_nxt;
  logic          r_gnt_b,    w_gnt_b_nxt;
  logic          r_last_b,   w_last_b_nxt;
  logic          r_rom_cs,   w_rom_cs_nxt;
  logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic [DW-1:0] r_data_a,   w_data_a_nxt;
  logic [DW-1:0] r_data_b,   w_data_b_nxt;
  logic [AW-1:0] r_addr_a,   w_addr_a_nxt;
  logic [AW-1:0] r_addr_b,   w_addr_b_nxt;
  logic          r_valid_a,  w_valid_a_nxt;
  logic          r_valid_b,  w_valid_b_nxt;

  logic w_ok_a, w_ok_b, w_pend_a, w_pend_b, w_pick_b;

  // The hit test is combinational so ok falls in the very cycle the address moves.
  assign w_ok_a   = a_cs & r_valid_a & (a_addr == r_addr_a);
  assign w_ok_b   = b_cs & r_valid_b & (b_addr == r_addr_b);
  assign w_pend_a = a_cs & ~w_ok_a;
  assign w_pend_b = b_cs & ~w_ok_b;
  assign w_pick_b = w_pend_b & (~w_pend_a | (RR & ~r_last_b));

  assign a_ok     = w_ok_a;
  assign b_ok     = w_ok_b;
  assign a_data   = r_data_a;
  assign b_data   = r_data_b;
  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_gnt_b_nxt    = r_gnt_b;
    w_last_b_nxt   = r_last_b;
    w_rom_cs_nxt   = r_rom_cs;
    w_rom_addr_nxt = r_rom_addr;
    w_data_a_nxt   = r_data_a;
    w_data_b_nxt   = r_data_b;
    w_addr_a_nxt   = r_addr_a;
    w_addr_b_nxt   = r_addr_b;
    w_valid_a_nxt  = r_valid_a;
    w_valid_b_nxt  = r_valid_b;

    case (r_state)
      ST_IDLE: begin
        w_rom_cs_nxt = 1'b0;
        if (w_pend_a | w_pend_b) begin
          w_gnt_b_nxt    = w_pick_b;
          w_rom_addr_nxt = w_pick_b ? b_addr : a_addr;
          w_rom_cs_nxt   = 1'b1;
          w_cnt_nxt      = CNT_INIT;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // rom_addr doubles as the granted address: it never moves while rom_cs is high.
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else if (rom_ok) begin
          if (r_gnt_b) begin
            w_data_b_nxt  = rom_data;
            w_addr_b_nxt  = r_rom_addr;
            w_valid_b_nxt = 1'b1;
          end else begin
            w_data_a_nxt  = rom_data;
            w_addr_a_nxt  = r_rom_addr;
            w_valid_a_nxt = 1'b1;
          end
          w_last_b_nxt = r_gnt_b;
          w_rom_cs_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_rom_cs_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values, independent of statement order.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 2'd0;
      r_gnt_b    <= 1'b0;
      r_last_b   <= 1'b1;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_valid_a  <= 1'b0;
      r_valid_b  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_last_b   <= w_last_b_nxt;
      r_rom_cs   <= w_rom_cs_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_data_a   <= w_data_a_nxt;
      r_data_b   <= w_data_b_nxt;
      r_addr_a   <= w_addr_a_nxt;
      r_addr_b   <= w_addr_b_nxt;
      r_valid_a  <= w_valid_a_nxt;
      r_valid_b  <= w_valid_b_nxt;
    end
  end

endmodule

// File: tb/tb_jtbubl_romarb.sv
// Directed bench for jtbubl_romarb: three instances cover round-robin, fixed priority and OKDLY=2.
module tb_jtbubl_romarb;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_cs, b_cs;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] rom_data;
  logic          ok_drv, dly_mode;

  logic [DW-1:0] a_data [3];
  logic [DW-1:0] b_data [3];
  logic          a_ok   [3];
  logic          b_ok   [3];
  logic          rom_cs [3];
  logic          rom_ok [3];
  logic [AW-1:0] rom_addr [3];

  logic [AW-1:0] exp_seq [6];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jtbubl_romarb #(.AW(AW), .DW(DW), .OKDLY(1), .PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_addr(a_addr), .a_data(a_data[0]), .a_ok(a_ok[0]),
    .b_cs(b_cs), .b_addr(b_addr), .b_data(b_data[0]), .b_ok(b_ok[0]),
    .rom_cs(rom_cs[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data), .rom_ok(rom_ok[0])
  );

  jtbubl_romarb #(.AW(AW), .DW(DW), .OKDLY(1), .PRIO(1)) u_pr (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_addr(a_addr), .a_data(a_data[1]), .a_ok(a_ok[1]),
    .b_cs(b_cs), .b_addr(b_addr), .b_data(b_data[1]), .b_ok(b_ok[1]),
    .rom_cs(rom_cs[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data), .rom_ok(rom_ok[1])
  );

  jtbubl_romarb #(.AW(AW), .DW(DW), .OKDLY(2), .PRIO(0)) u_d2 (
    .clk(clk), .rst(rst),
    .a_cs(a_cs), .a_addr(a_addr), .a_data(a_data[2]), .a_ok(a_ok[2]),
    .b_cs(b_cs), .b_addr(b_addr), .b_data(b_data[2]), .b_ok(b_ok[2]),
    .rom_cs(rom_cs[2]), .rom_addr(rom_addr[2]), .rom_data(rom_data), .rom_ok(rom_ok[2])
  );

  // SDRAM slot model: either a directly driven rom_ok, or ok 4 cycles after each rom_cs rise.
  for (genvar k = 0; k < 3; k++) begin : g_sdram
    logic [3:0] cnt;
    always @(posedge clk) begin
      if (!rom_cs[k])        cnt <= 4'd0;
      else if (cnt != 4'hF)  cnt <= cnt + 4'd1;
    end
    assign rom_ok[k] = dly_mode ? (rom_cs[k] && cnt >= 4'd4) : ok_drv;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Keeps both requesters pending and records rom_addr at each rom_cs rise.
  task automatic run_pair(input int k, input string tag);
    logic [AW-1:0] got [$];
    logic prev = 1'b0;
    int   cyc  = 0;
    while (got.size() < 6 && cyc < 400) begin
      step();
      cyc++;
      if (rom_cs[k] && !prev) got.push_back(rom_addr[k]);
      prev = rom_cs[k];
      if (a_ok[k]) a_addr = a_addr + 18'd1;
      if (b_ok[k]) b_addr = b_addr + 18'd1;
    end
    check({tag, "_grants"}, 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) check($sformatf("%s_seq%0d", tag, i), 64'(got[i]), 64'(exp_seq[i]));
  endtask

  initial begin
    rst      = 1'b1;
    a_cs     = 1'b0;
    b_cs     = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    rom_data = 32'hDEADBEEF;
    ok_drv   = 1'b1;
    dly_mode = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state, with rom_ok high while idle
    check("rst_rom_cs",   64'(rom_cs[0]),   64'd0);
    check("rst_rom_addr", 64'(rom_addr[0]), 64'd0);
    check("rst_a_data",   64'(a_data[0]),   64'd0);
    check("rst_b_data",   64'(b_data[0]),   64'd0);
    check("rst_a_ok",     64'(a_ok[0]),     64'd0);
    check("rst_b_ok",     64'(b_ok[0]),     64'd0);
    step();
    check("idle_ok_ignored", 64'(rom_cs[0]), 64'd0);

    // First fetch, latency with OKDLY=1
    a_cs   = 1'b1;
    a_addr = 18'h00010;
    step();
    check("f1_rom_cs",   64'(rom_cs[0]),   64'd1);
    check("f1_rom_addr", 64'(rom_addr[0]), 64'h10);
    check("f1_a_ok_c1",  64'(a_ok[0]),     64'd0);
    step();
    check("f1_a_ok_c2",  64'(a_ok[0]),     64'd0);
    step();
    check("f1_a_ok_c3",  64'(a_ok[0]),     64'd1);
    check("f1_a_data",   64'(a_data[0]),   64'hDEADBEEF);
    check("f1_b_ok",     64'(b_ok[0]),     64'd0);
    check("f1_cs_drop",  64'(rom_cs[0]),   64'd0);

    // Cache hit after cs has been low
    a_cs = 1'b0;
    #1;
    check("hit_ok_cs_low", 64'(a_ok[0]), 64'd0);
    repeat (5) step();
    check("hit_data_held", 64'(a_data[0]), 64'hDEADBEEF);
    a_cs = 1'b1;
    #1;
    check("hit_ok_same_cycle", 64'(a_ok[0]), 64'd1);
    step();
    check("hit_no_rom_cs", 64'(rom_cs[0]), 64'd0);
    a_addr = 18'h00011;
    #1;
    check("miss_ok_drop", 64'(a_ok[0]), 64'd0);
    step();
    check("miss_rom_cs",   64'(rom_cs[0]),   64'd1);
    check("miss_rom_addr", 64'(rom_addr[0]), 64'h11);
    step();
    step();
    check("miss_a_ok", 64'(a_ok[0]), 64'd1);
    a_cs = 1'b0;

    // B moves its address during WAIT
    b_cs     = 1'b1;
    b_addr   = 18'h00300;
    rom_data = 32'h00003000;
    step();
    check("bmv_rom_addr0", 64'(rom_addr[0]), 64'h300);
    b_addr = 18'h00304;
    step();
    check("bmv_addr_stable", 64'(rom_addr[0]), 64'h300);
    check("bmv_cs_stable",   64'(rom_cs[0]),   64'd1);
    step();
    check("bmv_b_ok_mismatch", 64'(b_ok[0]),   64'd0);
    check("bmv_b_data_old",    64'(b_data[0]), 64'h3000);
    check("bmv_cs_gap",        64'(rom_cs[0]), 64'd0);
    rom_data = 32'h00003040;
    step();
    check("bmv_rom_addr1", 64'(rom_addr[0]), 64'h304);
    check("bmv_rom_cs1",   64'(rom_cs[0]),   64'd1);
    step();
    step();
    check("bmv_b_ok",   64'(b_ok[0]),   64'd1);
    check("bmv_b_data", 64'(b_data[0]), 64'h3040);

    // Reset pulse in the middle of a fetch
    a_cs     = 1'b1;
    a_addr   = 18'h00020;
    rom_data = 32'h00002020;
    step();
    check("mrst_pre_cs", 64'(rom_cs[0]), 64'd1);
    do_reset();
    check("mrst_rom_cs", 64'(rom_cs[0]), 64'd0);
    check("mrst_a_ok",   64'(a_ok[0]),   64'd0);
    check("mrst_b_ok",   64'(b_ok[0]),   64'd0);
    check("mrst_b_data", 64'(b_data[0]), 64'd0);
    step();
    check("mrst_refetch_cs",   64'(rom_cs[0]),   64'd1);
    check("mrst_refetch_addr", 64'(rom_addr[0]), 64'h20);
    step();
    step();
    check("mrst_a_ok_after", 64'(a_ok[0]),   64'd1);
    check("mrst_a_data",     64'(a_data[0]), 64'h2020);
    step();
    check("mrst_b_refetch", 64'(rom_addr[0]), 64'h304);
    a_cs = 1'b0;
    b_cs = 1'b0;

    // Stale rom_ok with OKDLY=2: data switches just before the first unmasked sample
    do_reset();
    ok_drv   = 1'b1;
    rom_data = 32'hAAAA0001;
    a_cs     = 1'b1;
    a_addr   = 18'h00040;
    step();
    check("d2_rom_cs", 64'(rom_cs[2]), 64'd1);
    step();
    step();
    check("d2_masked_ok", 64'(a_ok[2]), 64'd0);
    rom_data = 32'h55550002;
    step();
    check("d2_a_ok",   64'(a_ok[2]),   64'd1);
    check("d2_a_data", 64'(a_data[2]), 64'h55550002);
    a_cs = 1'b0;

    // Round-robin with both requesters continuously pending
    step();
    do_reset();
    dly_mode = 1'b1;
    a_cs     = 1'b1;
    b_cs     = 1'b1;
    a_addr   = 18'h00100;
    b_addr   = 18'h00200;
    exp_seq[0] = 18'h100; exp_seq[1] = 18'h200; exp_seq[2] = 18'h101;
    exp_seq[3] = 18'h201; exp_seq[4] = 18'h102; exp_seq[5] = 18'h202;
    run_pair(0, "rr");

    // Fixed priority: A is served every time while it stays pending
    a_cs = 1'b0;
    b_cs = 1'b0;
    do_reset();
    a_cs   = 1'b1;
    b_cs   = 1'b1;
    a_addr = 18'h00100;
    b_addr = 18'h00200;
    exp_seq[0] = 18'h100; exp_seq[1] = 18'h101; exp_seq[2] = 18'h102;
    exp_seq[3] = 18'h103; exp_seq[4] = 18'h104; exp_seq[5] = 18'h105;
    run_pair(1, "prio");
    check("prio_b_never", 64'(b_ok[1]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
